pcie_noc_injector: RTL and testbench
====================================

Name: pcie_noc_injector

Overview:
- Ingress stage between the host PCIe stream and the main PE's NoC injection port.
- Buffers 256-bit PCIe beats and slices each beat into DATA_W-bit words.
- Wraps each word in a NoC flit {dest_y, dest_x, data} and issues the flits one at a time on a valid/ready handshake.
- Destinations are assigned round-robin across every mesh PE except (0,0), which hosts the PCIe endpoint.

Parameters:
- X, 2: mesh columns.
- Y, 2: mesh rows.
- X_W, 1: destination-x field width, >= clog2(X).
- Y_W, 1: destination-y field width, >= clog2(Y).
- DATA_W, 32: payload width; 256 must be divisible by DATA_W.
- FIFO_DEPTH, 4: beat FIFO entries, power of two.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- i_valid_pci, input, 1: PCIe beat valid.
- i_data_pci, input, 256: PCIe beat; word k = bits [k*DATA_W +: DATA_W]; word 0 is sent first.
- o_ready_pci, output, 1: beat accepted when i_valid_pci && o_ready_pci.
- o_valid, output, 1: flit valid toward the NoC.
- o_data, output, X_W+Y_W+DATA_W: flit = {dest_y, dest_x, payload}.
- i_ready, input, 1: NoC accepts the flit when o_valid && i_ready.
- o_word_cnt, output, 32: flits-sent counter (see Optional Feature).

Behaviour:
- Derived constants: BEAT_WORDS = 256/DATA_W; NPE = X*Y.
- Reset values (asserted asynchronously):
  - FIFO empty.
  - o_ready_pci = 1 (registered value of !full).
  - o_valid = 0; o_data = 0.
  - word index = 0; destination index = 1; o_word_cnt = 0.
  - state = IDLE.
- Reset mid-operation: any partially sent beat and all FIFO contents are discarded. No flit is emitted after reset until a new beat arrives.
- Beat FIFO:
  - o_ready_pci is a registered !full; no combinational path from any input.
  - A push happens only when o_ready_pci = 1.
  - Push and pop in the same cycle are allowed; occupancy is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full is detected at occupancy FIFO_DEPTH. o_ready_pci drops the cycle after the push that fills the FIFO, and rises the cycle after a pop from full.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty, pop the head into a 256-bit shift register, set word index = 0, go to SEND. o_valid is asserted from the next cycle.
  - SEND: o_valid = 1; o_data = {dest_y, dest_x, shreg[DATA_W-1:0]}.
    - On handshake: shift shreg right by DATA_W, increment word index, advance the destination.
    - If the word sent was the last (index = BEAT_WORDS-1) and the FIFO is non-empty: pop the next beat in the same cycle, stay in SEND. Result: back-to-back flits with no bubble.
    - If the word sent was the last and the FIFO is empty: go to IDLE; o_valid = 0 the next cycle.
  - Without a handshake: o_valid and o_data hold stable. o_valid never drops while a flit is pending.
- Destination counter:
  - dest_x = idx % X, dest_y = idx / X.
  - idx advances 1 → 2 → … → NPE-1 → 1; it wraps and never takes the value 0.
  - The counter is continuous across beats.
- Latency: a beat accepted at edge E into an empty block gives o_valid = 1 after edge E+1, i.e. the flit is visible in the cycle following E+1.
- Throughput: 1 flit/cycle while i_ready = 1. Sustained beat acceptance is 1 per BEAT_WORDS cycles.

Optional Feature:
- Macro: PCI_INJ_STATS_EN.
- Defined: o_word_cnt increments by 1 on each flit handshake and saturates at 32'hFFFF_FFFF. Reset clears it to 0.
- Undefined: o_word_cnt is tied to 0 and no counter logic is built. Port list is the same in both builds.

Test Plan:
- Reset then single beat 256'h…07_06_05_04_03_02_01_00 (DATA_W=32, word k = k), X=Y=2, i_ready=1:
  - o_valid rises 2 edges after acceptance.
  - Flits in order: payloads 0..7 with dests (1,0), (0,1), (1,1), (1,0), (0,1), (1,1), (1,0), (0,1).
  - Then o_valid = 0.
- i_ready=0, push 4 beats: o_ready_pci = 0 after the 4th push and a 5th beat is not taken. o_valid = 1 with word 0 held stable throughout.
- Two beats queued, i_ready=1: 16 consecutive flits with no idle cycle between word 7 of beat 0 and word 0 of beat 1.
- Toggle i_ready every cycle mid-beat: no flit lost or duplicated; o_data is unchanged while o_valid && !i_ready.
- Assert rst during word 3 of a beat with 2 beats queued:
  - Immediately: o_valid = 0, o_ready_pci = 1.
  - Next beat after release starts at payload word 0 with dest (1,0).
- With PCI_INJ_STATS_EN: after 3 beats, o_word_cnt = 24. With the counter preloaded to 32'hFFFF_FFFE via force, it sticks at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pcie_noc_injector.sv
// pcie_noc_injector: buffers 256-bit PCIe beats, slices them into DATA_W-bit words and injects them as round-robin NoC flits.
// Ports: clk, rst (async, active-high); i_valid_pci/i_data_pci/o_ready_pci = PCIe beat input;
// o_valid/o_data/i_ready = NoC flit output {dest_y, dest_x, payload}; o_word_cnt = flits-sent counter.
// Optional macro PCI_INJ_STATS_EN builds a saturating flit counter on o_word_cnt; without it o_word_cnt is tied to 0.
module pcie_noc_injector #(
  parameter int X          = 2,
  parameter int Y          = 2,
  parameter int X_W        = 1,
  parameter int Y_W        = 1,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid_pci,
  input  logic [255:0]              i_data_pci,
  output logic                      o_ready_pci,
  output logic                      o_valid,
  output logic [X_W+Y_W+DATA_W-1:0] o_data,
  input  logic                      i_ready,
  output logic [31:0]               o_word_cnt
);
  localparam int BEAT_WORDS = 256 / DATA_W;
  localparam int NPE = X * Y;
  localparam int W_W = BEAT_WORDS > 1 ? $clog2(BEAT_WORDS) : 1;
  localparam int P_W = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int D_W = $clog2(NPE);
  localparam logic [31:0] XU = 32'(X);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [255:0] mem [FIFO_DEPTH];
  logic [P_W-1:0] wr_ptr, rd_ptr;
  logic [P_W:0] count, count_nxt;
  logic [255:0] shreg;
  logic [W_W-1:0] widx;
  logic [D_W-1:0] didx;
  logic [X_W-1:0] dest_x;
  logic [Y_W-1:0] dest_y;
  logic push, pop, empty, hs, last, load;
  assign empty = count == '0;
  assign push = i_valid_pci && o_ready_pci;
  assign hs = o_valid && i_ready;
  assign last = widx == W_W'(BEAT_WORDS - 1);
  assign count_nxt = count + (P_W+1)'(push) - (P_W+1)'(pop);
  assign dest_x = X_W'(32'(didx) % XU);
  assign dest_y = Y_W'(32'(didx) / XU);
  assign o_valid = state == SEND;
  assign o_data = o_valid ? {dest_y, dest_x, shreg[DATA_W-1:0]} : '0;
  // A new beat is loaded when idle, or when the last word of the current beat leaves, so beats chain without a bubble.
  always_comb begin
    load = state == IDLE || (hs && last);
    pop = load && !empty;
    state_nxt = load ? (empty ? IDLE : SEND) : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= i_data_pci;
  // Ready is a registered !full so the PCIe side never sees a combinational path.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      o_ready_pci <= 1'b1;
    end else begin
      wr_ptr <= push ? wr_ptr + P_W'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + P_W'(1) : rd_ptr;
      count <= count_nxt;
      o_ready_pci <= count_nxt != (P_W+1)'(FIFO_DEPTH);
    end
  // Destination index skips 0: PE (0,0) hosts the PCIe endpoint.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg <= '0;
      widx <= '0;
      didx <= D_W'(1);
    end else begin
      if (pop) begin
        shreg <= mem[rd_ptr];
        widx <= '0;
      end else if (hs) begin
        shreg <= shreg >> DATA_W;
        widx <= widx + W_W'(1);
      end
      if (hs) didx <= didx == D_W'(NPE - 1) ? D_W'(1) : didx + D_W'(1);
    end
`ifdef PCI_INJ_STATS_EN
  logic [31:0] word_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) word_cnt <= '0;
    else if (hs && word_cnt != 32'hFFFF_FFFF) word_cnt <= word_cnt + 32'd1;
  assign o_word_cnt = word_cnt;
`else
  assign o_word_cnt = '0;
`endif
endmodule

// File: tb/tb_pcie_noc_injector.sv
// tb_pcie_noc_injector: directed scoreboard bench for pcie_noc_injector (X=Y=2, DATA_W=32).
module tb_pcie_noc_injector;
  logic clk = 0;
  logic rst = 1;
  logic i_valid_pci = 0;
  logic [255:0] i_data_pci = '0;
  logic o_ready_pci, o_valid, i_ready = 1;
  logic [33:0] o_data;
  logic [31:0] o_word_cnt;
  int tests = 0;
  int fails = 0;
  int m_idx = 1;
  logic [33:0] exp_q[$];
  logic prev_stall = 0;
  logic [33:0] prev_data;
  logic [33:0] exp;
  logic ok;
  pcie_noc_injector dut (
    .clk(clk), .rst(rst), .i_valid_pci(i_valid_pci), .i_data_pci(i_data_pci),
    .o_ready_pci(o_ready_pci), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_word_cnt(o_word_cnt)
  );
  always #5 clk = ~clk;
  // Sampled mid-cycle: inputs and outputs seen here are what the next rising edge acts on.
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        tests++;
        assert (o_valid === 1'b1 && o_data === prev_data) else begin
          fails++;
          $error("FAIL hold: valid=%b data=%h expected valid=1 data=%h", o_valid, o_data, prev_data);
        end
      end
      if (i_valid_pci && o_ready_pci)
        for (int k = 0; k < 8; k++) begin
          exp_q.push_back({1'(m_idx / 2), 1'(m_idx % 2), i_data_pci[k*32 +: 32]});
          m_idx = m_idx == 3 ? 1 : m_idx + 1;
        end
      if (o_valid && i_ready) begin
        tests++;
        ok = exp_q.size() > 0;
        exp = ok ? exp_q.pop_front() : '0;
        assert (ok && o_data === exp) else begin
          fails++;
          $error("FAIL flit: got=%h expected=%h (queue_had_entry=%b)", o_data, exp, ok);
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_data = o_data;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask
  task automatic push_beat(input logic [255:0] d);
    bit done = 0;
    i_valid_pci = 1;
    i_data_pci = d;
    for (int n = 0; n < 200 && !done; n++) begin
      done = o_ready_pci;
      tick(1);
    end
    i_valid_pci = 0;
    if (!done) check("push_timeout", 0, 1);
  endtask
  task automatic wait_drain(input int max);
    for (int n = 0; n < max && (exp_q.size() != 0 || o_valid); n++) tick(1);
    check("drain_queue", 64'(exp_q.size()), 0);
    check("drain_valid", 64'(o_valid), 0);
  endtask
  task automatic do_reset;
    rst = 1;
    exp_q.delete();
    m_idx = 1;
    tick(2);
    rst = 0;
    tick(1);
  endtask
  function automatic logic [255:0] rnd_beat();
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction
  initial begin
    logic [255:0] seq_beat;
    for (int k = 0; k < 8; k++) seq_beat[k*32 +: 32] = 32'(k);
    tick(2);
    check("rst_valid", 64'(o_valid), 0);
    check("rst_ready", 64'(o_ready_pci), 1);
    check("rst_data", 64'(o_data), 0);
    check("rst_cnt", 64'(o_word_cnt), 0);
    rst = 0;
    tick(1);
    push_beat(seq_beat);
    check("lat_e0_valid", 64'(o_valid), 0);
    tick(1);
    check("lat_e1_valid", 64'(o_valid), 1);
    check("first_flit", 64'(o_data), {30'd0, 2'b01, 32'd0});
    wait_drain(50);
    tick(3);
    check("idle_after_beat", 64'(o_valid), 0);
    i_ready = 0;
    push_beat(rnd_beat());
    tick(2);
    for (int b = 0; b < 4; b++) push_beat(rnd_beat());
    check("full_ready", 64'(o_ready_pci), 0);
    i_valid_pci = 1;
    i_data_pci = rnd_beat();
    for (int n = 0; n < 4; n++) begin
      check("full_ready_hold", 64'(o_ready_pci), 0);
      check("stall_valid", 64'(o_valid), 1);
      check("stall_data", 64'(o_data), 64'(exp_q[0]));
      tick(1);
    end
    i_valid_pci = 0;
    i_ready = 1;
    wait_drain(100);
    i_ready = 0;
    push_beat(rnd_beat());
    push_beat(rnd_beat());
    tick(2);
    i_ready = 1;
    for (int n = 0; n < 16; n++) begin
      check("b2b_valid", 64'(o_valid), 1);
      tick(1);
    end
    check("b2b_end_valid", 64'(o_valid), 0);
    check("b2b_queue", 64'(exp_q.size()), 0);
    push_beat(rnd_beat());
    for (int n = 0; n < 24; n++) begin
      i_ready = ~i_ready;
      tick(1);
    end
    i_ready = 1;
    wait_drain(50);
    i_ready = 0;
    for (int b = 0; b < 3; b++) push_beat(rnd_beat());
    tick(1);
    i_ready = 1;
    tick(3);
    check("pre_rst_valid", 64'(o_valid), 1);
    rst = 1;
    #1;
    check("async_rst_valid", 64'(o_valid), 0);
    check("async_rst_ready", 64'(o_ready_pci), 1);
    exp_q.delete();
    m_idx = 1;
    tick(2);
    rst = 0;
    tick(1);
    for (int n = 0; n < 4; n++) begin
      check("post_rst_idle", 64'(o_valid), 0);
      tick(1);
    end
    push_beat(seq_beat);
    tick(1);
    check("post_rst_first", 64'(o_data), {30'd0, 2'b01, 32'd0});
    wait_drain(50);
    do_reset();
    for (int b = 0; b < 3; b++) push_beat(rnd_beat());
    wait_drain(100);
`ifdef PCI_INJ_STATS_EN
    check("cnt_24", 64'(o_word_cnt), 24);
    force dut.word_cnt = 32'hFFFF_FFFE;
    tick(1);
    release dut.word_cnt;
    tick(1);
    check("cnt_preload", 64'(o_word_cnt), 64'h0000_0000_FFFF_FFFE);
    push_beat(rnd_beat());
    wait_drain(50);
    check("cnt_sat", 64'(o_word_cnt), 64'h0000_0000_FFFF_FFFF);
`else
    check("cnt_tied", 64'(o_word_cnt), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
